lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit LFSR pattern generator. It accepts one byte per `valid` beat from the generator's parallel output, which is the full register state. It self-synchronises by seeding its predictor from received data, then tracks the sequence and reports lock status and mismatches. It sits at the sink end of the pattern loop in the lab test harness and drives status LEDs and the seven-segment error display.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/lfsr_checker_if.sv | 21 ++
 rtl/lfsr_checker.sv | 110 +++++++++++
 tb/tb_lfsr_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions used by both the pattern generator and the checker,
// so the two ends of the loop always step the register identically.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 4, 3, 2 and 0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } chk_state_t;

    // The all-zero state injects a one, so the register can never stick at zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        logic fb;
        fb = (^(x & LFSR_TAPS)) ^ (x == 8'h00);
        return {fb, x[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Byte stream and status bundle between the LFSR pattern source and its checker.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             valid;
    logic [7:0]       din;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output valid, din, clr,
        input  locked, err, err_cnt
    );

    modport slave (
        input  valid, din, clr,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side LFSR sequence checker: self-seeds from received bytes, locks after
// a run of correct predictions and flywheels while locked. Error counter: LFSR_CHK_ERRCNT_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lfsr_checker_if.slave  bus
);

    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_ERR - 1);

    chk_state_t        state_r;
    logic [LFSR_W-1:0] pred_r;
    logic [3:0]        match_cnt_r;
    logic [3:0]        bad_cnt_r;
    logic              err_r;
    logic              locked_r;
    logic              hit_s;
    logic              err_inc_s;

    assign hit_s     = (bus.din == pred_r);
    assign err_inc_s = bus.valid && (state_r == LOCK) && !hit_s;

    // Hunt/sync/lock FSM with predictor and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            pred_r      <= 8'h00;
            match_cnt_r <= 4'd0;
            bad_cnt_r   <= 4'd0;
            err_r       <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (bus.valid) begin
                case (state_r)
                    HUNT: begin
                        pred_r      <= lfsr_next(bus.din);
                        match_cnt_r <= 4'd0;
                        state_r     <= SYNC;
                    end
                    SYNC: begin
                        pred_r <= lfsr_next(bus.din);
                        if (hit_s) begin
                            match_cnt_r <= match_cnt_r + 4'd1;
                            if (match_cnt_r == LOCK_LAST) begin
                                state_r   <= LOCK;
                                locked_r  <= 1'b1;
                                bad_cnt_r <= 4'd0;
                            end
                        end else begin
                            match_cnt_r <= 4'd0;
                        end
                    end
                    LOCK: begin
                        // Flywheel: never reseed from din, so one bad byte costs one error.
                        pred_r <= lfsr_next(pred_r);
                        if (hit_s) begin
                            bad_cnt_r <= 4'd0;
                        end else begin
                            err_r     <= 1'b1;
                            bad_cnt_r <= bad_cnt_r + 4'd1;
                            if (bad_cnt_r == UNLOCK_LAST) begin
                                state_r  <= HUNT;
                                locked_r <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.err    = err_r;
    assign bus.locked = locked_r;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Saturating mismatch counter; clr wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (bus.clr) begin
            err_cnt_r <= '0;
        end else if (err_inc_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`else
    logic unused_s;
    assign unused_s    = bus.clr ^ err_inc_s;
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker against a beat-level behavioural model.
module tb_lfsr_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_ERR = 3;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef LFSR_CHK_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

    lfsr_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_ERR(UNLOCK_ERR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_count  = 0;
    int fail_count = 0;
    int err_seen   = 0;

    // Model: mode 0 = no seed yet, 1 = acquiring, 2 = tracking.
    int         m_mode;
    logic [7:0] m_expect;
    int         m_run;
    int         m_miss;
    int         m_ecnt;
    bit         m_err;
    logic [7:0] g;

    function automatic logic [7:0] m_nxt(input logic [7:0] x);
        int  taps [4] = '{4, 3, 2, 0};
        logic fb;
        fb = (x == 8'h00);
        foreach (taps[k]) fb = fb ^ x[taps[k]];
        return (x >> 1) | ({7'd0, fb} << 7);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        cmp_count++;
        if (act != exp) begin
            fail_count++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_expect = 8'h00; m_run = 0; m_miss = 0; m_ecnt = 0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c);
        bit good;
        m_err = 1'b0;
        if (ERRCNT_EN && c) m_ecnt = 0;
        if (v) begin
            good = (d == m_expect);
            if (m_mode == 0) begin
                m_expect = m_nxt(d); m_run = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                m_expect = m_nxt(d);
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
                end else m_run = 0;
            end else begin
                m_expect = m_nxt(m_expect);
                if (good) m_miss = 0;
                else begin
                    m_err = 1'b1;
                    if (ERRCNT_EN && !c && m_ecnt < CNT_MAX) m_ecnt++;
                    m_miss++;
                    if (m_miss == UNLOCK_ERR) m_mode = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("locked", int'(bus.locked), int'(m_mode == 2));
        chk("err", int'(bus.err), int'(m_err));
        chk("err_cnt", int'(bus.err_cnt), m_ecnt);
        if (bus.err) err_seen++;
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge.
    task automatic tick(input bit v, input logic [7:0] d, input bit c);
        bus.valid = v; bus.din = d; bus.clr = c;
        if (rst_n) model_step(v, d, c);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_good();
        tick(1'b1, g, 1'b0);
        g = m_nxt(g);
    endtask

    task automatic send_bad();
        tick(1'b1, g ^ 8'h5A, 1'b0);
        g = m_nxt(g);
    endtask

    int e0;

    initial begin
        rst_n = 1'b0;
        bus.valid = 1'b0; bus.din = 8'h00; bus.clr = 1'b0;
        model_reset();
        repeat (3) tick(1'b1, 8'h33, 1'b0);
        chk("reset_locked", int'(bus.locked), 0);
        rst_n = 1'b1;

        chk("pin_nxt_10", int'(m_nxt(8'h10)), 8'h88);
        chk("pin_nxt_88", int'(m_nxt(8'h88)), 8'hC4);
        chk("pin_nxt_00", int'(m_nxt(8'h00)), 8'h80);
        chk("pin_nxt_01", int'(m_nxt(8'h01)), 8'h80);

        // Clean 01,80,40,20,10 then 88: locked right after the fifth beat.
        g = 8'h01;
        repeat (4) send_good();
        chk("lock_after_4", int'(bus.locked), 0);
        send_good();
        chk("lock_after_5", int'(bus.locked), 1);
        send_good();
        chk("no_err_clean", err_seen, 0);
        chk("errcnt_clean", int'(bus.err_cnt), 0);

        // Single corrupted byte in place of C4.
        e0 = err_seen;
        tick(1'b1, 8'h00, 1'b0);
        g = m_nxt(g);
        chk("single_err_pulse", int'(bus.err), 1);
        repeat (3) send_good();
        chk("single_err_count", err_seen - e0, 1);
        chk("single_err_locked", int'(bus.locked), 1);
        chk("single_err_cnt", int'(bus.err_cnt), ERRCNT_EN ? 1 : 0);

        // Three consecutive bad bytes unlock; gaps hold; clean run relocks.
        e0 = err_seen;
        send_bad();
        send_bad();
        chk("unlock_after_2", int'(bus.locked), 1);
        send_bad();
        chk("unlock_after_3", int'(bus.locked), 0);
        chk("unlock_pulses", err_seen - e0, 3);
        chk("unlock_cnt", int'(bus.err_cnt), ERRCNT_EN ? 4 : 0);
        tick(1'b0, 8'hAA, 1'b0);
        send_good();
        send_good();
        tick(1'b0, 8'h55, 1'b0);
        send_good();
        send_good();
        chk("relock_after_4", int'(bus.locked), 0);
        send_good();
        chk("relock_after_5", int'(bus.locked), 1);

        // Saturation with a 4-bit counter, then clr against a mismatch.
        tick(1'b0, 8'h00, 1'b1);
        chk("clr_idle", int'(bus.err_cnt), 0);
        for (int i = 0; i < 16; i++) begin
            send_bad();
            send_good();
        end
        chk("sat_cnt", int'(bus.err_cnt), ERRCNT_EN ? 15 : 0);
        chk("sat_locked", int'(bus.locked), 1);
        tick(1'b1, g ^ 8'h5A, 1'b1);
        g = m_nxt(g);
        chk("clr_vs_err_cnt", int'(bus.err_cnt), 0);
        chk("clr_vs_err_pulse", int'(bus.err), 1);

        // Asynchronous reset mid-lock with valid toggling.
        send_good();
        tick(1'b0, 8'h12, 1'b0);
        send_good();
        bus.valid = 1'b1; bus.din = g;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", int'(bus.locked), 0);
        chk("async_rst_err", int'(bus.err), 0);
        chk("async_rst_cnt", int'(bus.err_cnt), 0);
        model_reset();
        tick(1'b1, 8'h77, 1'b0);
        tick(1'b0, 8'h78, 1'b0);
        rst_n = 1'b1;

        // Zero escape: 00 then 80,40,20,10 locks from HUNT.
        g = 8'h00;
        repeat (4) send_good();
        chk("zero_lock_after_4", int'(bus.locked), 0);
        send_good();
        chk("zero_lock_after_5", int'(bus.locked), 1);
        repeat (2) send_good();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
